timing_sequencer: RTL and testbench

//   Upstream stage of micro_control. Produces its one-hot timing bus t[7:0] and its
//   one-hot instruction decode q[3:0].

---
 rtl/timing_sequencer.sv | 135 +++++++++++++
 tb/tb_timing_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/timing_sequencer.sv
// timing_sequencer
//   Upstream stage of micro_control. Steps a 3-bit sequence counter through
//   T0..T7 while running, latches the opcode into IR at T2 and decodes it
//   one-hot. Each opcode ends at its own last T step (END_Qn).
//
//   Ports
//     clk         in   system clock, rising edge
//     rst_n       in   synchronous reset, active low
//     start       in   leave IDLE and begin sequencing
//     stall       in   freeze the sequence (memory wait)
//     halt_req    in   stop at the next instruction boundary
//     op_in[1:0]  in   opcode from the data bus, sampled at T2
//     t[7:0]      out  one-hot timing state, 0 in IDLE
//     q[3:0]      out  one-hot decode of IR
//     busy        out  1 while in RUN (this is the FSM state)
//     instr_done  out  1-cycle pulse after an instruction completes
//     instr_count out  completed-instruction count, wraps
//
//   Handshake: start, stall and halt_req are level inputs sampled on every
//   rising edge; there is no ready/acknowledge. All outputs are taken
//   straight from registers, so nothing combinational reaches them from the
//   inputs.
module timing_sequencer #(
   parameter int END_Q0 = 3,
   parameter int END_Q1 = 3,
   parameter int END_Q2 = 5,
   parameter int END_Q3 = 7,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stall,
   input  logic             halt_req,
   input  logic [1:0]       op_in,
   output logic [7:0]       t,
   output logic [3:0]       q,
   output logic             busy,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [2:0] END0 = 3'(END_Q0);
   localparam logic [2:0] END1 = 3'(END_Q1);
   localparam logic [2:0] END2 = 3'(END_Q2);
   localparam logic [2:0] END3 = 3'(END_Q3);

   state_t           state, state_nxt;
   logic [2:0]       seq, seq_nxt;
   logic [1:0]       ir, ir_nxt;
   logic             halt_pend, halt_pend_nxt;
   logic             done_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [2:0]       end_step;

   // End detection uses the registered IR. Since every END is at least 3,
   // the opcode loaded at T2 is already in IR when it is first compared.
   always_comb begin
      end_step = END0;
      case (ir)
         2'd0: end_step = END0;
         2'd1: end_step = END1;
         2'd2: end_step = END2;
         2'd3: end_step = END3;
         default: end_step = END0;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      seq_nxt       = seq;
      ir_nxt        = ir;
      halt_pend_nxt = halt_pend;
      done_nxt      = 1'b0;
      cnt_nxt       = instr_count;
      case (state)
         IDLE: begin
            // halt_req is ignored here, so start always wins.
            if (start) begin
               state_nxt = RUN;
               seq_nxt   = 3'd0;
            end
         end
         RUN: begin
            if (stall) begin
               // Frozen, but a halt request is still remembered.
               if (halt_req) halt_pend_nxt = 1'b1;
            end else begin
               if (seq == 3'd2) ir_nxt = op_in;
               if (seq == end_step) begin
                  // Completion also covers END=7: seq returns to 0 here,
                  // never by overflow.
                  seq_nxt  = 3'd0;
                  done_nxt = 1'b1;
                  cnt_nxt  = instr_count + 1'b1;
                  if (halt_req || halt_pend) begin
                     state_nxt     = IDLE;
                     halt_pend_nxt = 1'b0;
                  end
               end else begin
                  seq_nxt = seq + 3'd1;
                  if (halt_req) halt_pend_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         seq         <= 3'd0;
         ir          <= 2'd0;
         halt_pend   <= 1'b0;
         instr_done  <= 1'b0;
         instr_count <= '0;
      end else begin
         state       <= state_nxt;
         seq         <= seq_nxt;
         ir          <= ir_nxt;
         halt_pend   <= halt_pend_nxt;
         instr_done  <= done_nxt;
         instr_count <= cnt_nxt;
      end
   end

   // t stays 0 in IDLE so no spurious T0 controls leak downstream.
   assign busy = (state == RUN);
   assign t    = busy ? (8'h01 << seq) : 8'h00;
   assign q    = 4'h1 << ir;

endmodule

// File: tb/tb_timing_sequencer.sv
module tb_timing_sequencer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default parameters.
   logic       rst_n = 1'b0, start = 1'b0, stall = 1'b0, halt_req = 1'b0;
   logic [1:0] op_in = 2'd0;
   logic [7:0] t;
   logic [3:0] q;
   logic       busy, instr_done;
   logic [7:0] instr_count;

   // Instance B: 2-bit completed-instruction counter.
   logic       b_rst_n = 1'b0, b_start = 1'b0, b_stall = 1'b0, b_halt = 1'b0;
   logic [1:0] b_op = 2'd0;
   logic [7:0] b_t;
   logic [3:0] b_q;
   logic       b_busy, b_done;
   logic [1:0] b_cnt;

   timing_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .halt_req(halt_req), .op_in(op_in), .t(t), .q(q), .busy(busy),
      .instr_done(instr_done), .instr_count(instr_count)
   );

   timing_sequencer #(.CNT_W(2)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .start(b_start), .stall(b_stall),
      .halt_req(b_halt), .op_in(b_op), .t(b_t), .q(b_q), .busy(b_busy),
      .instr_done(b_done), .instr_count(b_cnt)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst_n, start, stall, halt;
      logic [1:0] op;
      logic [7:0] t;
      logic [3:0] q;
      logic       busy, done;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic s, input logic st,
                               input logic h, input logic [1:0] op,
                               input logic [7:0] et, input logic [3:0] eq,
                               input logic eb, input logic ed,
                               input logic [7:0] ec);
      vec_t v;
      v.rst_n = r; v.start = s; v.stall = st; v.halt = h; v.op = op;
      v.t = et; v.q = eq; v.busy = eb; v.done = ed; v.cnt = ec;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply inputs, take one edge, compare every output of instance A.
   task automatic step_a(input string name, input vec_t v);
      rst_n = v.rst_n; start = v.start; stall = v.stall;
      halt_req = v.halt; op_in = v.op;
      @(posedge clk); #1;
      check({name, ".t"},    32'(t),           32'(v.t));
      check({name, ".q"},    32'(q),           32'(v.q));
      check({name, ".busy"}, 32'(busy),        32'(v.busy));
      check({name, ".done"}, 32'(instr_done),  32'(v.done));
      check({name, ".cnt"},  32'(instr_count), 32'(v.cnt));
   endtask

   task automatic step_b(input string name, input logic r, input logic s,
                         input logic st, input logic [7:0] et,
                         input logic ed, input logic [1:0] ec);
      b_rst_n = r; b_start = s; b_stall = st; b_halt = 1'b0; b_op = 2'd0;
      @(posedge clk); #1;
      check({name, ".t"},    32'(b_t),    32'(et));
      check({name, ".done"}, 32'(b_done), 32'(ed));
      check({name, ".cnt"},  32'(b_cnt),  32'(ec));
   endtask

   initial begin
      logic [1:0] exp_cnt;

      // 1) op 11: T0..T7, q=1000 from T3, done during the second T0.
      tbl.push_back(mk(0,0,0,0,2'd3, 8'h00,4'h1,0,0,8'd0));
      tbl.push_back(mk(1,1,0,0,2'd3, 8'h01,4'h1,1,0,8'd0));
      tbl.push_back(mk(1,0,0,0,2'd3, 8'h02,4'h1,1,0,8'd0));
      tbl.push_back(mk(1,0,0,0,2'd3, 8'h04,4'h1,1,0,8'd0));
      tbl.push_back(mk(1,0,0,0,2'd3, 8'h08,4'h8,1,0,8'd0));
      tbl.push_back(mk(1,0,0,0,2'd3, 8'h10,4'h8,1,0,8'd0));
      tbl.push_back(mk(1,0,0,0,2'd3, 8'h20,4'h8,1,0,8'd0));
      tbl.push_back(mk(1,0,0,0,2'd3, 8'h40,4'h8,1,0,8'd0));
      tbl.push_back(mk(1,0,0,0,2'd3, 8'h80,4'h8,1,0,8'd0));
      tbl.push_back(mk(1,0,0,0,2'd3, 8'h01,4'h8,1,1,8'd1));
      // 2) op 01: four-cycle instruction; start ignored while running.
      tbl.push_back(mk(1,1,0,0,2'd1, 8'h02,4'h8,1,0,8'd1));
      tbl.push_back(mk(1,0,0,0,2'd1, 8'h04,4'h8,1,0,8'd1));
      tbl.push_back(mk(1,0,0,0,2'd1, 8'h08,4'h2,1,0,8'd1));
      tbl.push_back(mk(1,0,0,0,2'd1, 8'h01,4'h2,1,1,8'd2));
      // 3) op 10 with a 3-cycle stall at T4.
      tbl.push_back(mk(1,0,0,0,2'd2, 8'h02,4'h2,1,0,8'd2));
      tbl.push_back(mk(1,0,0,0,2'd2, 8'h04,4'h2,1,0,8'd2));
      tbl.push_back(mk(1,0,0,0,2'd2, 8'h08,4'h4,1,0,8'd2));
      tbl.push_back(mk(1,0,0,0,2'd2, 8'h10,4'h4,1,0,8'd2));
      tbl.push_back(mk(1,0,1,0,2'd2, 8'h10,4'h4,1,0,8'd2));
      tbl.push_back(mk(1,0,1,0,2'd2, 8'h10,4'h4,1,0,8'd2));
      tbl.push_back(mk(1,0,1,0,2'd2, 8'h10,4'h4,1,0,8'd2));
      tbl.push_back(mk(1,0,0,0,2'd2, 8'h20,4'h4,1,0,8'd2));
      tbl.push_back(mk(1,0,0,0,2'd2, 8'h01,4'h4,1,1,8'd3));

      for (int i = 0; i < tbl.size(); i++)
         step_a($sformatf("vec%0d", i), tbl[i]);

      // 4) op 10, halt_req pulsed at T1: run to T5, then drop to IDLE.
      step_a("halt_t1",  mk(1,0,0,1,2'd2, 8'h02,4'h4,1,0,8'd3));
      step_a("halt_t2",  mk(1,0,0,0,2'd2, 8'h04,4'h4,1,0,8'd3));
      step_a("halt_t3",  mk(1,0,0,0,2'd2, 8'h08,4'h4,1,0,8'd3));
      step_a("halt_t4",  mk(1,0,0,0,2'd2, 8'h10,4'h4,1,0,8'd3));
      step_a("halt_t5",  mk(1,0,0,0,2'd2, 8'h20,4'h4,1,0,8'd3));
      step_a("halt_end", mk(1,0,0,0,2'd2, 8'h00,4'h4,0,1,8'd4));
      step_a("idle",     mk(1,0,0,1,2'd2, 8'h00,4'h4,0,0,8'd4));
      // start with halt_req in IDLE: start wins, halt is dropped, so the
      // op 00 instruction completes and the sequencer stays in RUN.
      step_a("sh_t0",    mk(1,1,0,1,2'd0, 8'h01,4'h4,1,0,8'd4));
      step_a("sh_t1",    mk(1,0,0,0,2'd0, 8'h02,4'h4,1,0,8'd4));
      step_a("sh_t2",    mk(1,0,0,0,2'd0, 8'h04,4'h4,1,0,8'd4));
      step_a("sh_t3",    mk(1,0,0,0,2'd0, 8'h08,4'h1,1,0,8'd4));
      step_a("sh_end",   mk(1,0,0,0,2'd0, 8'h01,4'h1,1,1,8'd5));
      // 5) reset in the middle of op 11 at T5.
      step_a("rst_t1",   mk(1,0,0,0,2'd3, 8'h02,4'h1,1,0,8'd5));
      step_a("rst_t2",   mk(1,0,0,0,2'd3, 8'h04,4'h1,1,0,8'd5));
      step_a("rst_t3",   mk(1,0,0,0,2'd3, 8'h08,4'h8,1,0,8'd5));
      step_a("rst_t4",   mk(1,0,0,0,2'd3, 8'h10,4'h8,1,0,8'd5));
      step_a("rst_t5",   mk(1,0,0,0,2'd3, 8'h20,4'h8,1,0,8'd5));
      step_a("rst_mid",  mk(0,0,0,0,2'd3, 8'h00,4'h1,0,0,8'd0));

      // 6) CNT_W=2: five back-to-back op 00 instructions, count wraps.
      //    The third one stalls 2 cycles at its END step (T3).
      step_b("b_rst",   0, 0, 0, 8'h00, 0, 2'd0);
      step_b("b_start", 1, 1, 0, 8'h01, 0, 2'd0);
      exp_cnt = 2'd0;
      for (int n = 0; n < 5; n++) begin
         step_b($sformatf("b%0d_t1", n), 1, 0, 0, 8'h02, 0, exp_cnt);
         step_b($sformatf("b%0d_t2", n), 1, 0, 0, 8'h04, 0, exp_cnt);
         step_b($sformatf("b%0d_t3", n), 1, 0, 0, 8'h08, 0, exp_cnt);
         if (n == 2) begin
            step_b("b2_stall0", 1, 0, 1, 8'h08, 0, exp_cnt);
            step_b("b2_stall1", 1, 0, 1, 8'h08, 0, exp_cnt);
         end
         exp_cnt = exp_cnt + 2'd1;
         step_b($sformatf("b%0d_end", n), 1, 0, 0, 8'h01, 1, exp_cnt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
